// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - cycle-based 16-bit SRAM pin-level responder with read latency and violation counting
module sram_responder #(
  parameter int MEM_AW   = 16,
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  input  logic        SRAM_UB_N,
  input  logic        SRAM_LB_N,
  input  logic        SRAM_WE_N,
  input  logic        SRAM_CE_N,
  input  logic        SRAM_OE_N,
  output logic        rd_valid,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {IDLE, WAIT, DRIVE} state_t;

  localparam logic [2:0] LAT_LOAD = 3'(READ_LAT - 1);

  state_t              state, state_n;
  logic [2:0]          lat_cnt, lat_n;
  logic [MEM_AW-1:0]   addr_q, addr_n, addr_w;
  logic [7:0]          err_n;
  logic [15:0]         mem [0:(1<<MEM_AW)-1];
  logic [15:0]         rd_data;
  logic                rd_req, wr_en, stray, restart, collision, drive;
  logic                unused_addr_hi;

  assign addr_w         = SRAM_ADDR[MEM_AW-1:0];
  assign unused_addr_hi = ^SRAM_ADDR[17:MEM_AW];
  assign rd_req         = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign wr_en          = !SRAM_CE_N && !SRAM_WE_N;
  assign stray          = SRAM_CE_N && !SRAM_WE_N;

  always_comb begin
    state_n   = state;
    lat_n     = lat_cnt;
    addr_n    = addr_q;
    restart   = 1'b0;
    collision = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req) begin
          addr_n  = addr_w;
          lat_n   = LAT_LOAD;
          state_n = (READ_LAT == 1) ? DRIVE : WAIT;
        end
      end
      WAIT: begin
        if (SRAM_CE_N || SRAM_OE_N) begin
          state_n = IDLE;
        end else if (SRAM_WE_N && (addr_w != addr_q)) begin
          restart = 1'b1;
          addr_n  = addr_w;
          lat_n   = LAT_LOAD;
          state_n = (READ_LAT == 1) ? DRIVE : WAIT;
        end else if (lat_cnt <= 3'd1) begin
          lat_n   = 3'd0;
          state_n = DRIVE;
        end else begin
          lat_n = lat_cnt - 3'd1;
        end
      end
      DRIVE: begin
        if (!SRAM_WE_N) begin
          collision = 1'b1;
          state_n   = IDLE;
        end else if (SRAM_CE_N || SRAM_OE_N) begin
          state_n = IDLE;
        end else if (addr_w != addr_q) begin
          addr_n  = addr_w;
          lat_n   = LAT_LOAD;
          state_n = (READ_LAT == 1) ? DRIVE : WAIT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Several simultaneous violations still count once.
  always_comb begin
    err_n = err_count;
    if ((stray || restart || collision) && (err_count != 8'hFF)) begin
      err_n = err_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lat_cnt   <= 3'd0;
      addr_q    <= '0;
      err_count <= 8'd0;
    end else begin
      state     <= state_n;
      lat_cnt   <= lat_n;
      addr_q    <= addr_n;
      err_count <= err_n;
    end
  end

  // Array has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (!SRAM_LB_N) mem[addr_w][7:0]  <= SRAM_DQ[7:0];
      if (!SRAM_UB_N) mem[addr_w][15:8] <= SRAM_DQ[15:8];
    end
  end

  assign rd_data  = mem[addr_q];
  assign drive    = (state == DRIVE) && SRAM_WE_N;
  assign rd_valid = drive;

  assign SRAM_DQ[7:0]  = (drive && !SRAM_LB_N) ? rd_data[7:0]  : 8'hzz;
  assign SRAM_DQ[15:8] = (drive && !SRAM_UB_N) ? rd_data[15:8] : 8'hzz;

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - directed and randomized bench for sram_responder against a byte-level memory model
module tb_sram_responder;

  localparam int AW = 16;
  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [17:0] addr;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;
  logic [15:0] tb_dq;
  logic        tb_en;
  wire  [15:0] dq;
  logic        rd_valid;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  assign dq = tb_en ? tb_dq : 16'hzzzz;
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (dq[i]);
  end

  sram_responder #(.MEM_AW(AW), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_DQ(dq),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .rd_valid(rd_valid), .err_count(err_count)
  );

  int checks   = 0;
  int failures = 0;
  int exp_err  = 0;
  logic [15:0] m_data  [int];
  logic [1:0]  m_known [int];
  int          wr_keys [$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; tb_en = 1'b0; ub_n = 1'b1; lb_n = 1'b1;
  endtask

  task automatic model_write(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb);
    int k;
    logic [15:0] v;
    logic [1:0]  kn;
    k  = int'(a[AW-1:0]);
    v  = m_data.exists(k)  ? m_data[k]  : 16'h0000;
    kn = m_known.exists(k) ? m_known[k] : 2'b00;
    if (!lb) begin v[7:0]  = d[7:0];  kn[0] = 1'b1; end
    if (!ub) begin v[15:8] = d[15:8]; kn[1] = 1'b1; end
    m_data[k]  = v;
    m_known[k] = kn;
    if (kn != 2'b00) wr_keys.push_back(k);
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb);
    addr = a; tb_dq = d; tb_en = 1'b1; ub_n = ub; lb_n = lb;
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'($urandom_range(0, 1));
    cyc();
    model_write(a, d, ub, lb);
    idle();
  endtask

  // Inputs already request a read of a; the next edge is the launch.
  task automatic expect_data(input logic [17:0] a, input string tag);
    int k;
    logic [15:0] e, m, md;
    logic [1:0]  kn;
    k  = int'(a[AW-1:0]);
    md = m_data.exists(k)  ? m_data[k]  : 16'h0000;
    kn = m_known.exists(k) ? m_known[k] : 2'b00;
    e  = 16'hFFFF;
    m  = 16'hFFFF;
    if (!lb_n) begin if (kn[0]) e[7:0]  = md[7:0];  else m[7:0]  = 8'h00; end
    if (!ub_n) begin if (kn[1]) e[15:8] = md[15:8]; else m[15:8] = 8'h00; end
    for (int i = 1; i < RL; i++) begin
      cyc();
      check({tag, "_early"}, {15'd0, rd_valid}, 16'd0);
    end
    cyc();
    check({tag, "_valid"}, {15'd0, rd_valid}, 16'd1);
    check({tag, "_data"}, dq & m, e & m);
  endtask

  task automatic do_read(input logic [17:0] a, input logic ub, input logic lb, input string tag);
    addr = a; ub_n = ub; lb_n = lb; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; tb_en = 1'b0;
    expect_data(a, tag);
  endtask

  initial begin
    int drive_key;
    int k;
    logic [17:0] a;
    logic [1:0]  ln;

    idle();
    addr = '0;
    tb_dq = '0;
    rst = 1'b0;
    repeat (3) cyc();
    check("rst_rd_valid", {15'd0, rd_valid}, 16'd0);
    check("rst_err", {8'd0, err_count}, 16'd0);
    check("rst_dq_z", dq, 16'hFFFF);
    rst = 1'b1;
    cyc();

    // byte lanes and latency
    do_write(18'h00010, 16'hA55A, 1'b0, 1'b0);
    do_write(18'h00010, 16'h7733, 1'b1, 1'b0);
    do_read(18'h00010, 1'b0, 1'b0, "lane_rd");
    check("lane_merge", dq, 16'hA533);
    ub_n = 1'b1; #1;
    check("lane_ub_off", dq, 16'hFF33);
    ub_n = 1'b0; #1;
    check("lane_ub_on", dq, 16'hA533);
    idle(); cyc();

    // aliasing above MEM_AW
    do_write(18'h10005, 16'h1234, 1'b0, 1'b0);
    do_read(18'h00005, 1'b0, 1'b0, "alias");
    check("alias_lit", dq, 16'h1234);
    idle(); cyc();

    // restart one cycle after launch
    do_write(18'd3, 16'h3131, 1'b0, 1'b0);
    do_write(18'd4, 16'h4242, 1'b0, 1'b0);
    addr = 18'd3; ub_n = 1'b0; lb_n = 1'b0; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    cyc();
    addr = 18'd4;
    exp_err++;
    expect_data(18'd4, "restart");
    check("restart_err", {8'd0, err_count}, 16'(exp_err));
    idle(); cyc();

    // collision while driving
    do_write(18'd7, 16'h7007, 1'b0, 1'b0);
    do_read(18'd7, 1'b0, 1'b0, "pre_coll");
    we_n = 1'b0; #1;
    check("coll_release", dq, 16'hFFFF);
    check("coll_rd_valid", {15'd0, rd_valid}, 16'd0);
    tb_dq = 16'hBEEF; tb_en = 1'b1;
    cyc();
    model_write(18'd7, 16'hBEEF, 1'b0, 1'b0);
    exp_err++;
    check("coll_err", {8'd0, err_count}, 16'(exp_err));
    we_n = 1'b1; tb_en = 1'b0;
    expect_data(18'd7, "post_coll");
    check("coll_lit", dq, 16'hBEEF);
    idle(); cyc();

    // randomized traffic, no violations expected
    drive_key = -1;
    for (int n = 0; n < 60; n++) begin
      if (wr_keys.size() == 0 || $urandom_range(0, 2) == 0) begin
        idle(); cyc();
        a  = 18'($urandom);
        ln = 2'($urandom);
        do_write(a, 16'($urandom), ln[1], ln[0]);
        drive_key = -1;
      end else begin
        k  = wr_keys[$urandom_range(0, wr_keys.size() - 1)];
        a  = {2'($urandom), 16'(k)};
        ln = 2'($urandom);
        if (drive_key == k || $urandom_range(0, 1) == 1) begin
          idle(); cyc();
        end
        do_read(a, ln[1], ln[0], "rand_rd");
        drive_key = k;
      end
      check("rand_err", {8'd0, err_count}, 16'(exp_err));
    end
    idle(); cyc();

    // stray writes and saturation
    addr = 18'h00010; tb_dq = 16'h5A5A; tb_en = 1'b1; ub_n = 1'b0; lb_n = 1'b0;
    ce_n = 1'b1; we_n = 1'b0;
    repeat (300) cyc();
    exp_err = (exp_err + 300 > 255) ? 255 : exp_err + 300;
    check("sat_err", {8'd0, err_count}, 16'(exp_err));
    idle(); cyc();
    do_read(18'h00010, 1'b0, 1'b0, "stray_unchanged");
    idle(); cyc();

    // reset during WAIT
    addr = 18'h00010; ub_n = 1'b0; lb_n = 1'b0; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    cyc();
    #2 rst = 1'b0; #1;
    exp_err = 0;
    check("rstw_rd_valid", {15'd0, rd_valid}, 16'd0);
    check("rstw_dq_z", dq, 16'hFFFF);
    check("rstw_err", {8'd0, err_count}, 16'(exp_err));
    cyc();
    rst = 1'b1;
    expect_data(18'h00010, "rstw_after");

    // reset during DRIVE releases the bus at once
    #2 rst = 1'b0; #1;
    check("rstd_rd_valid", {15'd0, rd_valid}, 16'd0);
    check("rstd_dq_z", dq, 16'hFFFF);
    idle(); cyc();
    rst = 1'b1;
    do_read(18'd7, 1'b0, 1'b0, "rstd_after");
    idle(); cyc();
    do_read(18'h00005, 1'b0, 1'b0, "rstd_alias");
    idle(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
